// File: rtl/flag_cond_unit.sv
// NZCV flag register with exception save/restore and a one-deep registered
// ARM condition-check result stage with valid/ready handshake.
module flag_cond_unit (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       flag_we,
    input  logic [3:0] new_flag,
    output logic [3:0] flags,
    input  logic       cond_valid,
    input  logic [3:0] cond,
    output logic       cond_ready,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       cond_pass,
    input  logic       exc_entry,
    input  logic       exc_return,
    output logic [3:0] saved_flags
);

    // Flag layout: [3]=N [2]=Z [1]=C [0]=V
    function automatic logic cond_eval(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v;
        logic r;
        n  = f[3];
        z  = f[2];
        cy = f[1];
        v  = f[0];
        unique case (c)
            4'd0:    r = z;
            4'd1:    r = !z;
            4'd2:    r = cy;
            4'd3:    r = !cy;
            4'd4:    r = n;
            4'd5:    r = !n;
            4'd6:    r = v;
            4'd7:    r = !v;
            4'd8:    r = cy && !z;
            4'd9:    r = !cy || z;
            4'd10:   r = (n == v);
            4'd11:   r = (n != v);
            4'd12:   r = !z && (n == v);
            4'd13:   r = z || (n != v);
            4'd14:   r = 1'b1;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    logic [3:0] eff_flags;
    logic       accept;
    logic       pass_p0;

    // Restore bypass wins over the commit bypass so an instruction issued
    // alongside exc_return sees the flags it will actually run under.
    always_comb begin
        eff_flags = flags;
        if (exc_return)
            eff_flags = saved_flags;
        else if (flag_we)
            eff_flags = new_flag;
    end

    assign cond_ready = !out_valid || out_ready;
    assign accept     = cond_valid && cond_ready;
    assign pass_p0    = cond_eval(cond, eff_flags);

    // Architectural flag state: commits and save/restore ignore the handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags       <= 4'b0000;
            saved_flags <= 4'b0000;
        end else begin
            if (exc_return)
                flags <= saved_flags;
            else if (flag_we)
                flags <= new_flag;
            if (exc_entry && !exc_return)
                saved_flags <= eff_flags;
        end
    end

    // Result stage: registered pass bit, overwritten in place on back-to-back accepts
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            cond_pass <= 1'b0;
        end else begin
            if (accept) begin
                out_valid <= 1'b1;
                cond_pass <= pass_p0;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_flag_cond_unit.sv
// Directed self-checking bench for flag_cond_unit: flag commit, condition
// decode, handshake stall/drain, exception save/restore and async reset.
module tb_flag_cond_unit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       flag_we;
    logic [3:0] new_flag;
    logic [3:0] flags;
    logic       cond_valid;
    logic [3:0] cond;
    logic       cond_ready;
    logic       out_valid;
    logic       out_ready;
    logic       cond_pass;
    logic       exc_entry;
    logic       exc_return;
    logic [3:0] saved_flags;

    int n_asserts = 0;
    int n_fail    = 0;

    flag_cond_unit dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flag_we    (flag_we),
        .new_flag   (new_flag),
        .flags      (flags),
        .cond_valid (cond_valid),
        .cond       (cond),
        .cond_ready (cond_ready),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .cond_pass  (cond_pass),
        .exc_entry  (exc_entry),
        .exc_return (exc_return),
        .saved_flags(saved_flags)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_asserts++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n      = 1'b0;
        flag_we    = 1'b0;
        new_flag   = 4'b0000;
        cond_valid = 1'b1;
        cond       = 4'd14;
        out_ready  = 1'b1;
        exc_entry  = 1'b0;
        exc_return = 1'b0;
        #3;
        chk("rst_flags", flags, 4'b0000);
        chk("rst_saved", saved_flags, 4'b0000);
        chk("rst_out_valid", {3'b0, out_valid}, 4'd0);
        chk("rst_cond_pass", {3'b0, cond_pass}, 4'd0);
        chk("rst_cond_ready", {3'b0, cond_ready}, 4'd1);
        tick();
        chk("rst_no_capture", {3'b0, out_valid}, 4'd0);

        // Commit Z with EQ check in the same cycle
        rst_n    = 1'b1;
        flag_we  = 1'b1;
        new_flag = 4'b0100;
        cond     = 4'd0;
        tick();
        chk("eq_valid", {3'b0, out_valid}, 4'd1);
        chk("eq_pass", {3'b0, cond_pass}, 4'd1);
        chk("eq_flags", flags, 4'b0100);

        // N=1 V=1 via bypass, GE
        new_flag = 4'b1001;
        cond     = 4'd10;
        tick();
        chk("ge_pass", {3'b0, cond_pass}, 4'd1);
        chk("flags_1001", flags, 4'b1001);
        flag_we = 1'b0;
        cond    = 4'd11;
        tick();
        chk("lt_pass", {3'b0, cond_pass}, 4'd0);
        chk("lt_valid", {3'b0, out_valid}, 4'd1);
        cond = 4'd12;
        tick();
        chk("gt_pass", {3'b0, cond_pass}, 4'd1);
        cond = 4'd15;
        tick();
        chk("nv_pass", {3'b0, cond_pass}, 4'd0);
        cond = 4'd9;
        tick();
        chk("ls_pass", {3'b0, cond_pass}, 4'd1);
        cond = 4'd8;
        tick();
        chk("hi_pass", {3'b0, cond_pass}, 4'd0);
        cond = 4'd4;
        tick();
        chk("mi_pass", {3'b0, cond_pass}, 4'd1);

        // Stall: result held while out_ready=0
        cond = 4'd14;
        tick();
        chk("al_pass", {3'b0, cond_pass}, 4'd1);
        out_ready = 1'b0;
        cond      = 4'd15;
        #1;
        chk("stall_ready", {3'b0, cond_ready}, 4'd0);
        flag_we  = 1'b1;
        new_flag = 4'b0100;
        for (int i = 0; i < 3; i++) begin
            tick();
            flag_we = 1'b0;
            chk("stall_valid", {3'b0, out_valid}, 4'd1);
            chk("stall_pass", {3'b0, cond_pass}, 4'd1);
            chk("stall_ready_hold", {3'b0, cond_ready}, 4'd0);
        end
        chk("stall_flag_commit", flags, 4'b0100);
        out_ready = 1'b1;
        #1;
        chk("drain_ready", {3'b0, cond_ready}, 4'd1);
        tick();
        chk("drain_new_valid", {3'b0, out_valid}, 4'd1);
        chk("drain_new_pass", {3'b0, cond_pass}, 4'd0);
        cond_valid = 1'b0;
        tick();
        chk("drain_empty", {3'b0, out_valid}, 4'd0);

        // Exception save / restore
        flag_we  = 1'b1;
        new_flag = 4'b0010;
        tick();
        flag_we   = 1'b0;
        exc_entry = 1'b1;
        tick();
        chk("save_0010", saved_flags, 4'b0010);
        exc_entry = 1'b0;
        flag_we   = 1'b1;
        new_flag  = 4'b1000;
        tick();
        chk("flags_1000", flags, 4'b1000);
        exc_return = 1'b1;
        exc_entry  = 1'b1;
        new_flag   = 4'b0101;
        cond_valid = 1'b1;
        cond       = 4'd2;
        tick();
        chk("restore_flags", flags, 4'b0010);
        chk("restore_saved", saved_flags, 4'b0010);
        chk("restore_bypass_pass", {3'b0, cond_pass}, 4'd1);
        exc_return = 1'b0;
        new_flag   = 4'b0110;
        cond_valid = 1'b0;
        tick();
        chk("save_bypass", saved_flags, 4'b0110);
        chk("flags_0110", flags, 4'b0110);

        // Async reset mid-handshake
        exc_entry  = 1'b0;
        new_flag   = 4'b1111;
        out_ready  = 1'b0;
        cond_valid = 1'b1;
        cond       = 4'd14;
        tick();
        chk("pre_rst_valid", {3'b0, out_valid}, 4'd1);
        chk("pre_rst_flags", flags, 4'b1111);
        flag_we = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", {3'b0, out_valid}, 4'd0);
        chk("arst_flags", flags, 4'b0000);
        chk("arst_saved", saved_flags, 4'b0000);
        chk("arst_pass", {3'b0, cond_pass}, 4'd0);
        tick();
        chk("arst_hold_valid", {3'b0, out_valid}, 4'd0);
        rst_n      = 1'b1;
        cond_valid = 1'b0;
        out_ready  = 1'b1;
        tick();
        chk("no_replay", {3'b0, out_valid}, 4'd0);
        cond_valid = 1'b1;
        cond       = 4'd1;
        tick();
        chk("post_rst_valid", {3'b0, out_valid}, 4'd1);
        chk("post_rst_ne_pass", {3'b0, cond_pass}, 4'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
